// File: rtl/risc_wb_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, load results queue in a small FIFO.
// Optional macro WB_LSU_BYPASS_EN lets an LSU result skip the empty FIFO when the port is idle.
module risc_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [AW-1:0]            lsu_rd,
  input  logic [DW-1:0]            lsu_data,
  output logic                     WE3,
  output logic [AW-1:0]            A3,
  output logic [DW-1:0]            WD3,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    rd_mem_q   [DEPTH];
  logic [DW-1:0]    data_mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             we_q;
  logic [AW-1:0]    a3_q;
  logic [DW-1:0]    wd_q;

  logic fifo_empty, bypass, push, pop;

  assign fifo_empty = (count_q == '0);
  assign lsu_ready  = rst && (count_q != CW'(DEPTH));

`ifdef WB_LSU_BYPASS_EN
  assign bypass = rst && fifo_empty && !alu_valid && lsu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = lsu_valid && lsu_ready && !bypass;
  assign pop  = rst && !alu_valid && !fifo_empty;

  // Payload storage carries no reset; the per-entry valid bits define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= lsu_rd;
      data_mem_q[wr_ptr_q] <= lsu_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_q[gi] <= 1'b0;
        end else if (push && (wr_ptr_q == PW'(gi))) begin
          valid_q[gi] <= 1'b1;
        end else if (pop && (rd_ptr_q == PW'(gi))) begin
          valid_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      a3_q     <= '0;
      wd_q     <= '0;
    end else begin
      if (alu_valid) begin
        we_q <= (alu_rd != '0);
        a3_q <= alu_rd;
        wd_q <= alu_data;
      end else if (!fifo_empty) begin
        we_q <= (rd_mem_q[rd_ptr_q] != '0);
        a3_q <= rd_mem_q[rd_ptr_q];
        wd_q <= data_mem_q[rd_ptr_q];
      end else if (bypass) begin
        we_q <= (lsu_rd != '0);
        a3_q <= lsu_rd;
        wd_q <= lsu_data;
      end else begin
        we_q <= 1'b0;
      end

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Duplicate destinations naturally keep their bit set until the last one leaves.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) busy_mask = busy_mask | (32'(1) << rd_mem_q[i]);
    end
    busy_mask[0] = 1'b0;
  end

  assign WE3        = we_q;
  assign A3         = a3_q;
  assign WD3        = wd_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_risc_wb_arbiter.sv
// Randomized bench for risc_wb_arbiter against a queue-based reference model and a shadow register file.
module tb_risc_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [31:0]   busy_mask;
  logic [$clog2(DEPTH):0] fifo_count;

  risc_wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           model_q[$];
  logic          exp_we;
  logic [AW-1:0] exp_a3;
  logic [DW-1:0] exp_wd;
  logic [DW-1:0] model_rf [32];
  logic [DW-1:0] dut_rf   [32];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    foreach (model_q[i]) m[model_q[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock of stimulus: drive after negedge, apply the model's rules at posedge, check at next negedge.
  task automatic cycle(input logic r, input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    logic ready;
    logic accept;
    logic consumed;
    int   reg_sel;
    wb_t  h;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    ready = r && (model_q.size() != DEPTH);
    check("lsu_ready", 64'(lsu_ready), 64'(ready));

    @(posedge clk);
    if (!r) begin
      model_q.delete();
      exp_we = 1'b0; exp_a3 = '0; exp_wd = '0;
    end else begin
      accept   = lv && ready;
      consumed = 1'b0;
      if (av) begin
        exp_we = (ard != 0); exp_a3 = ard; exp_wd = ad;
      end else if (model_q.size() > 0) begin
        h = model_q.pop_front();
        exp_we = (h.rd != 0); exp_a3 = h.rd; exp_wd = h.data;
`ifdef WB_LSU_BYPASS_EN
      end else if (accept) begin
        exp_we = (lrd != 0); exp_a3 = lrd; exp_wd = ld;
        consumed = 1'b1;
`endif
      end else begin
        exp_we = 1'b0;
      end
      if (accept && !consumed) model_q.push_back('{rd: lrd, data: ld});
    end

    @(negedge clk);
    if (WE3 === 1'b1) dut_rf[A3] = WD3;
    if (exp_we) model_rf[exp_a3] = exp_wd;
    check("WE3", 64'(WE3), 64'(exp_we));
    if (exp_we) begin
      check("A3", 64'(A3), 64'(exp_a3));
      check("WD3", 64'(WD3), 64'(exp_wd));
    end else if (!r) begin
      check("A3_rst", 64'(A3), 64'(0));
      check("WD3_rst", 64'(WD3), 64'(0));
    end
    check("fifo_count", 64'(fifo_count), 64'(model_q.size()));
    check("busy_mask", 64'(busy_mask), 64'(model_busy()));
    reg_sel = $urandom_range(0, 31);
    check($sformatf("rf_x%0d", reg_sel), 64'(dut_rf[reg_sel]), 64'(model_rf[reg_sel]));
    check("rf_x0", 64'(dut_rf[0]), 64'(0));
    $display("cyc rst=%0b alu=%0b/%0d lsu=%0b/%0d -> WE3=%0b A3=%0d WD3=%h cnt=%0d busy=%h",
             r, av, ard, lv, lrd, WE3, A3, WD3, fifo_count, busy_mask);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    int alu_pct;
    int lsu_pct;
    exp_we = 1'b0; exp_a3 = '0; exp_wd = '0;
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
    rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

    // Reset held with both requesters active
    cycle(1'b0, 1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
    cycle(1'b0, 1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
    // ALU path
    cycle(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    idle(1);
    // LSU entry queued behind three ALU cycles
    cycle(1'b1, 1'b1, 5'd10, 32'hA, 1'b1, 5'd7, 32'h1234_5678);
    cycle(1'b1, 1'b1, 5'd11, 32'hB, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 5'd12, 32'hC, 1'b0, '0, '0);
    idle(2);
    // Fill the FIFO, offer a fifth beat, then drain
    for (int i = 1; i <= 5; i++)
      cycle(1'b1, 1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i));
    idle(6);
    // Writes to x0
    cycle(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    idle(2);
    // Idle port with a single LSU result
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 32'hA5A5_A5A5);
    idle(3);

    // Random phases vary ALU pressure so the FIFO both fills and drains
    for (int ph = 0; ph < 30; ph++) begin
      alu_pct = $urandom_range(0, 95);
      lsu_pct = $urandom_range(20, 90);
      for (int i = 0; i < 80; i++) begin
        cycle(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 99) < alu_pct), 5'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 99) < lsu_pct),
              ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
              $urandom);
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/risc_wb_arbiter.md
Name: risc_wb_arbiter

Overview:
- Writer side of the 32x32 register file's single write port (WE3/A3/WD3).
- Merges ALU-pipeline results (no backpressure) with load-unit results (valid/ready) into one registered write stream.
- LSU results wait in a small FIFO while ALU traffic holds the port.
- Exports a pending-write scoreboard so hazard logic can stall readers of registers still queued.

Parameters:
- DEPTH, 4, LSU FIFO entries; power of 2, range 2..16
- DW, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU writeback request this cycle; always accepted
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- lsu_valid  in  1  load-unit result valid
- lsu_ready  out  1  FIFO can accept a load-unit result
- lsu_rd  in  AW  load destination register
- lsu_data  in  DW  load data
- WE3  out  1  register-file write enable (registered)
- A3  out  AW  register-file write address (registered)
- WD3  out  DW  register-file write data (registered)
- busy_mask  out  32  bit r = 1 when a queued, unwritten LSU entry targets r; bit 0 always 0
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (rst=0 at posedge): WE3=0, A3=0, WD3=0, FIFO emptied (rd/wr pointers 0, fifo_count=0), busy_mask=0. lsu_ready=0 while rst=0. Reset mid-operation discards queued entries; no write is issued for them.
- Outputs are registered at posedge. The register file commits on the following negedge, so a write issued at edge N is readable after the negedge of cycle N.
- Handshake: an LSU transfer occurs when lsu_valid && lsu_ready at posedge. lsu_ready = rst && (fifo_count != DEPTH), evaluated on pre-edge state. A full FIFO drops lsu_ready even if a dequeue happens in the same cycle.
- Port arbitration, evaluated each posedge in this order:
  - If alu_valid: WE3 <= (alu_rd != 0), A3 <= alu_rd, WD3 <= alu_data. No dequeue.
  - Else if FIFO non-empty: dequeue the head; WE3 <= (head.rd != 0), A3/WD3 <= head fields.
  - Else: WE3 <= 0; A3/WD3 hold their previous values.
- Writes to x0 are accepted and consumed but never assert WE3.
- Simultaneous enqueue and dequeue: both performed; fifo_count unchanged.
- Ordering:
  - The LSU stream is strict FIFO order.
  - ALU writes preempt queued LSU entries. WAW correctness against queued loads is the hazard unit's job: it must stall an ALU instruction whose rd has busy_mask[rd]=1.
- busy_mask:
  - Combinational OR of one-hot(rd) over valid FIFO entries.
  - A bit clears on the edge where that entry is dequeued.
  - Duplicate rds in the FIFO keep the bit set until the last matching entry leaves.
- Latency:
  - ALU: 1 cycle to WE3.
  - LSU: minimum 2 cycles (enqueue edge, then dequeue edge); +1 per ALU-occupied cycle ahead of it.
- Pointers wrap modulo DEPTH. fifo_count saturates by construction at DEPTH (no overflow possible given lsu_ready).

Optional Feature:
- Macro: WB_LSU_BYPASS_EN.
- Defined: when FIFO empty, alu_valid=0 and lsu_valid=1, the LSU result goes straight to WE3/A3/WD3 at that posedge, skipping the FIFO. LSU latency is 1 cycle, fifo_count stays 0, and busy_mask never shows the bypassed rd.
- Undefined: every LSU result is enqueued; minimum LSU latency is 2 cycles.

Test Plan:
- Reset: rst=0 for 2 cycles with lsu_valid=1 and alu_valid=1 -> WE3=0, A3=0, WD3=0, lsu_ready=0, fifo_count=0 throughout; first write appears only on the edge after rst=1.
- ALU path: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; readback of x5 after the negedge = 0xDEADBEEF.
- LSU queued:
  - Stimulus: LSU rd=7, data=0x12345678 while alu_valid=1 for 3 cycles.
  - Expected: fifo_count=1, busy_mask=0x00000080 during those cycles; the cycle after alu_valid drops, WE3=1, A3=7; busy_mask returns to 0.
- Full FIFO: 4 LSU beats (rd 1..4) with alu_valid=1 -> lsu_ready=0 and fifo_count=4; a 5th lsu_valid is not accepted; after ALU idles, writes drain in order A3=1,2,3,4 on consecutive cycles.
- x0 drop: ALU rd=0 data=0xFFFFFFFF, then LSU rd=0 -> WE3 stays 0; x0 reads 0; the LSU entry still consumes one dequeue cycle.
- Bypass: WB_LSU_BYPASS_EN defined, idle, LSU rd=9 data=0xA5A5A5A5 -> WE3=1, A3=9 one cycle later, fifo_count=0. Undefined: the same stimulus gives the write 2 cycles later.
